// File: rtl/multicycle_core_pkg.sv
// Shared opcodes, state/ALU/immediate enums and decode helpers for multicycle_core.
// Optional counters are enabled with the MULTICYCLE_CORE_PERF_EN macro in the top module.
package multicycle_core_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;
  localparam logic [5:0]  OP_B_HI    = 6'b000101;
  localparam logic [8:0]  OP_MOVZ_HI = 9'b110100101;

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_D9, IMM_CB19, IMM_B26, IMM_MOV16
  } imm_fmt_e;

  typedef enum logic [2:0] {
    INS_RTYPE, INS_LDUR, INS_STUR, INS_CBZ, INS_B, INS_MOVZ, INS_ILLEGAL
  } ins_class_e;

  function automatic ins_class_e decode_class(input logic [10:0] opc);
    ins_class_e cls;
    if (opc == OP_ADD || opc == OP_SUB || opc == OP_AND || opc == OP_ORR) cls = INS_RTYPE;
    else if (opc == OP_LDUR)            cls = INS_LDUR;
    else if (opc == OP_STUR)            cls = INS_STUR;
    else if (opc[10:3] == OP_CBZ_HI)    cls = INS_CBZ;
    else if (opc[10:5] == OP_B_HI)      cls = INS_B;
    else if (opc[10:2] == OP_MOVZ_HI)   cls = INS_MOVZ;
    else                                cls = INS_ILLEGAL;
    return cls;
  endfunction

  function automatic alu_op_e decode_alu_op(input ins_class_e cls, input logic [10:0] opc);
    alu_op_e op;
    case (cls)
      INS_RTYPE: begin
        case (opc)
          OP_SUB:  op = ALU_SUB;
          OP_AND:  op = ALU_AND;
          OP_ORR:  op = ALU_ORR;
          default: op = ALU_ADD;
        endcase
      end
      INS_MOVZ: op = ALU_PASSB;
      default:  op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic imm_fmt_e decode_imm_fmt(input ins_class_e cls);
    imm_fmt_e fmt;
    case (cls)
      INS_LDUR, INS_STUR: fmt = IMM_D9;
      INS_CBZ:            fmt = IMM_CB19;
      INS_B:              fmt = IMM_B26;
      INS_MOVZ:           fmt = IMM_MOV16;
      default:            fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/multicycle_core_regfile.sv
// Two-read/one-write register file; the top index (NREGS-1) is XZR, reads 0 and ignores writes.
module regfile_2r1w
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS  = 32
) (
  input  logic                 CLK,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [DATA_W-1:0]    wd,
  output logic [DATA_W-1:0]    rd1,
  output logic [DATA_W-1:0]    rd2
);

  localparam logic [REG_IDX_W-1:0] XZR_IDX = REG_IDX_W'(NREGS - 1);

  logic [DATA_W-1:0] regs_r [NREGS];

  // Combinational read ports; XZR and any index past it read as zero
  always_comb begin
    if (ra1 >= XZR_IDX) rd1 = '0;
    else                rd1 = regs_r[ra1];
    if (ra2 >= XZR_IDX) rd2 = '0;
    else                rd2 = regs_r[ra2];
  end

  // Architectural registers are deliberately not reset
  always_ff @(posedge CLK) begin
    if (we && (wa < XZR_IDX)) regs_r[wa] <= wd;
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle LEGv8 subset core on one handshaked unified memory.
// Define MULTICYCLE_CORE_PERF_EN to add the perf_cycles / perf_retired counters.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int NREGS  = 32
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [ADDR_W-1:0] startpc,
  output logic [ADDR_W-1:0] currentpc,
  output logic [DATA_W-1:0] MemtoRegOut,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted
`ifdef MULTICYCLE_CORE_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_retired
`endif
);

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  state_e            state_r;
  logic [31:0]       ir_r;
  ins_class_e        cls_r;
  alu_op_e           alu_op_r;
  logic [DATA_W-1:0] op_a_r;
  logic [DATA_W-1:0] op_b_r;
  logic [DATA_W-1:0] imm_r;

  ins_class_e          cls_s;
  imm_fmt_e            imm_fmt_s;
  logic [REG_IDX_W-1:0] rn_idx_s;
  logic [REG_IDX_W-1:0] rm_idx_s;
  logic [DATA_W-1:0]   rn_val_s;
  logic [DATA_W-1:0]   rm_val_s;
  logic [DATA_W-1:0]   imm_s;
  logic [6:0]          mov_sh_s;
  logic [DATA_W-1:0]   alu_b_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic [ADDR_W-1:0]   pc_plus4_s;
  logic [ADDR_W-1:0]   branch_target_s;
  logic [ADDR_W-1:0]   redirect_pc_s;
  logic                cbz_taken_s;
  logic                rf_we_s;

  assign cls_s     = decode_class(ir_r[31:21]);
  assign imm_fmt_s = decode_imm_fmt(cls_s);
  assign rf_we_s   = (state_r == ST_WB);

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .CLK (CLK),
    .ra1 (rn_idx_s),
    .ra2 (rm_idx_s),
    .we  (rf_we_s),
    .wa  (ir_r[4:0]),
    .wd  (MemtoRegOut),
    .rd1 (rn_val_s),
    .rd2 (rm_val_s)
  );

  // Register-port selection: STUR/CBZ read their Rt through the second port
  always_comb begin
    rn_idx_s = ir_r[9:5];
    if (cls_s == INS_STUR || cls_s == INS_CBZ) rm_idx_s = ir_r[4:0];
    else                                       rm_idx_s = ir_r[20:16];
  end

  // Immediate extender; branch offsets are pre-shifted to byte offsets
  always_comb begin
    imm_s    = '0;
    mov_sh_s = {1'b0, ir_r[22:21], 4'b0000};
    case (imm_fmt_s)
      IMM_D9:   imm_s = {{(DATA_W-9){ir_r[20]}}, ir_r[20:12]};
      IMM_CB19: imm_s = {{(DATA_W-21){ir_r[23]}}, ir_r[23:5], 2'b00};
      IMM_B26:  imm_s = {{(DATA_W-28){ir_r[25]}}, ir_r[25:0], 2'b00};
      IMM_MOV16: begin
        if ({25'd0, mov_sh_s} >= 32'(DATA_W)) imm_s = '0;
        else imm_s = {{(DATA_W-16){1'b0}}, ir_r[20:5]} << mov_sh_s;
      end
      default:  imm_s = '0;
    endcase
  end

  // ALU, operating on the operands latched in DECODE
  always_comb begin
    if (cls_r == INS_RTYPE) alu_b_s = op_b_r;
    else                    alu_b_s = imm_r;
    case (alu_op_r)
      ALU_ADD:   alu_res_s = op_a_r + alu_b_s;
      ALU_SUB:   alu_res_s = op_a_r - alu_b_s;
      ALU_AND:   alu_res_s = op_a_r & alu_b_s;
      ALU_ORR:   alu_res_s = op_a_r | alu_b_s;
      ALU_PASSB: alu_res_s = alu_b_s;
      default:   alu_res_s = op_a_r + alu_b_s;
    endcase
  end

  // Next-PC selection; all PC arithmetic wraps modulo 2^ADDR_W
  always_comb begin
    pc_plus4_s      = currentpc + PC_STEP;
    branch_target_s = currentpc + imm_r[ADDR_W-1:0];
    cbz_taken_s     = (op_b_r == '0);
    if (state_r == ST_EXEC && (cls_r == INS_B || (cls_r == INS_CBZ && cbz_taken_s)))
      redirect_pc_s = branch_target_s;
    else
      redirect_pc_s = pc_plus4_s;
  end

  // Control FSM; every memory-interface output is registered
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_r     <= ST_BOOT;
      currentpc   <= '0;
      ir_r        <= '0;
      MemtoRegOut <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      halted      <= 1'b0;
      cls_r       <= INS_ILLEGAL;
      alu_op_r    <= ALU_ADD;
      op_a_r      <= '0;
      op_b_r      <= '0;
      imm_r       <= '0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          currentpc <= startpc;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= startpc;
          state_r   <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem_req && mem_ack) begin
            ir_r    <= mem_rdata[31:0];
            mem_req <= 1'b0;
            state_r <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (cls_s == INS_ILLEGAL) begin
            halted  <= 1'b1;
            state_r <= ST_HALT;
          end else begin
            cls_r    <= cls_s;
            alu_op_r <= decode_alu_op(cls_s, ir_r[31:21]);
            op_a_r   <= rn_val_s;
            op_b_r   <= rm_val_s;
            imm_r    <= imm_s;
            state_r  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_r)
            INS_RTYPE, INS_MOVZ: begin
              MemtoRegOut <= alu_res_s;
              state_r     <= ST_WB;
            end
            INS_LDUR, INS_STUR: begin
              mem_req   <= 1'b1;
              mem_we    <= (cls_r == INS_STUR);
              mem_addr  <= alu_res_s[ADDR_W-1:0];
              mem_wdata <= op_b_r;
              state_r   <= ST_MEM;
            end
            INS_CBZ, INS_B: begin
              currentpc <= redirect_pc_s;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= redirect_pc_s;
              state_r   <= ST_FETCH;
            end
            default: begin
              halted  <= 1'b1;
              mem_req <= 1'b0;
              state_r <= ST_HALT;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_req && mem_ack) begin
            if (cls_r == INS_LDUR) begin
              MemtoRegOut <= mem_rdata;
              mem_req     <= 1'b0;
              mem_we      <= 1'b0;
              state_r     <= ST_WB;
            end else begin
              currentpc <= redirect_pc_s;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= redirect_pc_s;
              state_r   <= ST_FETCH;
            end
          end
        end
        ST_WB: begin
          currentpc <= redirect_pc_s;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= redirect_pc_s;
          state_r   <= ST_FETCH;
        end
        ST_HALT: begin
          halted  <= 1'b1;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: state_r <= ST_BOOT;
      endcase
    end
  end

`ifdef MULTICYCLE_CORE_PERF_EN
  logic retire_s;

  // An instruction retires when it leaves its last state
  always_comb begin
    if (state_r == ST_EXEC && (cls_r == INS_B || cls_r == INS_CBZ)) retire_s = 1'b1;
    else if (state_r == ST_MEM && mem_req && mem_ack && cls_r == INS_STUR) retire_s = 1'b1;
    else if (state_r == ST_WB) retire_s = 1'b1;
    else retire_s = 1'b0;
  end

  // Free-running cycle and retirement counters, wrapping at 2^32
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      perf_cycles  <= 32'd0;
      perf_retired <= 32'd0;
    end else begin
      if (state_r != ST_BOOT && state_r != ST_HALT) perf_cycles <= perf_cycles + 32'd1;
      if (retire_s) perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the team's single-cycle LEGv8 processor. It executes the same instruction subset through an explicit state machine against one unified, handshaked external memory that holds both instructions and data. Data width, address width and register count are generalised, and illegal opcodes halt the core. It replaces the single-cycle datapath wherever memory has variable latency.

## Interface
Parameters:
- DATA_W, default 64: register and ALU width; must be a multiple of 16, at least 32.
- ADDR_W, default 64: memory address width; must satisfy ADDR_W ≤ DATA_W.
- NREGS, default 32: architectural registers; index NREGS-1 is XZR.

Ports:
- CLK  in  1  clock.
- resetl  in  1  reset; one clock, reset asynchronous and active-low.
- startpc  in  ADDR_W  boot PC; sampled in BOOT.
- currentpc  out  ADDR_W  PC of the instruction in flight.
- MemtoRegOut  out  DATA_W  write-back data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load or fetch data; instruction in bits [31:0].
- mem_ack  in  1  request completes this cycle.
- halted  out  1  core stopped on an illegal opcode.

## Operation
- Opcodes [31:21]:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100xxx, B 000101xxxxx.
  - MOVZ 110100101hh, where hh = shift/16.
  - Anything else is illegal.
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- BOOT → FETCH: currentpc ← startpc.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=currentpc.
  - On mem_ack: IR ← mem_rdata[31:0]; go to DECODE.
- DECODE:
  - Read Rn=IR[9:5]; second port reads IR[4:0] for STUR/CBZ, otherwise IR[20:16].
  - Latch the sign-extended immediate.
  - Illegal opcode → HALT.
- EXEC:
  - R-type and MOVZ → WB.
  - LDUR/STUR: address = Rn + sext(imm9) → MEM.
  - CBZ: PC ← PC + (sext(imm19)<<2) if Rt==0, else PC+4 → FETCH.
  - B: PC ← PC + (sext(imm26)<<2) → FETCH.
- MEM:
  - Hold mem_req, mem_addr and mem_wdata until mem_ack.
  - LDUR → WB.
  - STUR: PC+4 → FETCH.
- WB:
  - Write Rd=IR[4:0] with MemtoRegOut, unless Rd is XZR.
  - PC ← PC+4 → FETCH.
- HALT: absorbing until reset; halted=1, mem_req=0.
- Arithmetic:
  - Modulo 2^DATA_W.
  - PC arithmetic modulo 2^ADDR_W, so it wraps through 0.
  - Addresses are the low ADDR_W bits of the ALU result.
  - MOVZ result = imm16 << (16·hh); 0 if 16·hh ≥ DATA_W.
- XZR reads as 0. Writes to XZR are discarded.

## Timing
- Reset asserted (asynchronous):
  - State → BOOT.
  - currentpc=0, IR=0, MemtoRegOut=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - Registers are not cleared.
- Reset mid-request drops mem_req immediately. The memory must tolerate the abandoned access.
- mem_ack is sampled only while mem_req=1, and may be high in the same cycle as the request (zero wait). mem_ack with mem_req=0 is ignored.
- Minimum cycles per instruction at zero wait (BOOT excluded):
  - B, CBZ: 3.
  - R-type, MOVZ, STUR: 4.
  - LDUR: 5.
  - Each wait cycle adds one.
- The register write and the PC update both occur on the WB clock edge. MemtoRegOut is valid throughout WB.

## Configuration
- MULTICYCLE_CORE_PERF_EN defined:
  - Adds outputs perf_cycles and perf_retired, each 32 bits, reset to 0.
  - perf_cycles counts every non-HALT cycle after BOOT.
  - perf_retired increments on each instruction's final state exit.
  - Both wrap at 2^32.
- Undefined: no counters and no extra ports.

## Structure
- Package multicycle_core_pkg holds:
  - The opcode constants.
  - The state enum.
  - The ALU-op enum.
  - The immediate-format enum.
- Sub-module regfile_2r1w(DATA_W, NREGS): two combinational read ports, one write port on CLK, XZR handling inside.
- FSM, ALU, immediate extender and PC logic live in the top module.

## Test plan
- Reset release with startpc=0x100 and zero-wait memory → first mem_addr=0x100 on the cycle after BOOT; no mem_req during BOOT.
- MOVZ X1,#5; MOVZ X2,#7; ADD X3,X1,X2 → MemtoRegOut=12 in WB; ADD completes in 4 cycles.
- STUR X3,[X0,#8] with X0=0x200, then LDUR X4,[X0,#8], with mem_ack delayed by 3 cycles → store at addr 0x208 with wdata 12; X4=12; LDUR takes 8 cycles.
- CBZ X31,#-2 at PC 0x40 → next fetch at 0x38. CBZ on a nonzero register at 0x40 → next fetch at 0x44.
- Fetch of word 0xFFFFFFFF → halted=1 after DECODE; mem_req stays 0; resetl low clears halted.
- ADD X31,X1,X1 followed by a reset pulse during a pending FETCH → X31 still reads 0; mem_req falls asynchronously; the core restarts from startpc.
